thor2024_fetch_buffer: RTL and testbench
========================================

Name: thor2024_fetch_buffer

Overview:
- Double-pair instruction fetch buffer (pairs AB and CD) sitting between the I-cache/PC register and the enqueue stage.
- Captures two instructions per fetch at `pc` and presents the active pair to enqueue.
- Detects backward conditional branches and generates the `fetchbufX_v`, `backbrX`, `fetchbuf`, `branchback`, `backpc` and `did_branchback` signals consumed by the program-counter register.

Parameters:
- INSN_W, 40, instruction width in bits.
- PC_W, 32, PC width.
- INSN_BYTES, 5, byte stride between the two instructions of a pair.
- BR_MASK, 7'h78, opcode mask applied to insn[6:0].
- BR_VAL, 7'h28, masked opcode value identifying a conditional branch.
- DISP_LSB, 19, LSB of the signed branch displacement field insn[INSN_W-1:DISP_LSB].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hit  in  1  I-cache hit for `pc`
- irq  in  1  interrupt pending; blocks fill
- pc  in  PC_W  fetch address from PC register
- insn0  in  INSN_W  instruction at `pc`
- insn1  in  INSN_W  instruction at pc+INSN_BYTES
- branchmiss  in  1  flush all buffers
- enq_cnt  in  2  slots taken from active pair this cycle (0..2)
- fetchbuf  out  1  active pair: 0=AB, 1=CD
- fetchbufA_v..fetchbufD_v  out  1 each  slot valid
- backbrA..backbrD  out  1 each  slot holds a backward branch (decode only, independent of valid)
- branchback  out  1  valid backward branch in active pair
- backpc  out  PC_W  target of earliest valid backward branch in active pair
- did_branchback  out  1  redirect already issued for slot 1 of active pair
- fb0_instr, fb1_instr  out  INSN_W  active pair slot 0/1 instruction
- fb0_pc, fb1_pc  out  PC_W  active pair slot 0/1 PC
- fb0_v, fb1_v  out  1  active pair slot 0/1 valid

Behaviour:
- Reset: all four valids 0, fetchbuf 0, did_branchback 0, stored instr/pc 0. Reset beats every other event, including mid-fill or mid-consume.
- Slot mapping: fetchbuf=0 → slot0=A, slot1=B; fetchbuf=1 → slot0=C, slot1=D.
- Decode, per slot:
  - backbr = ((instr[6:0] & BR_MASK) == BR_VAL) & instr[INSN_W-1].
  - target = slot_pc + sign-extended instr[INSN_W-1:DISP_LSB], modulo 2^PC_W.
- Combinational outputs:
  - branchback = (slot0_v & backbr0) | (slot1_v & backbr1).
  - backpc = target0 if slot0_v & backbr0, else target1.
  - fb*_ signals mux the active pair.
- All decisions below use registered state at the start of the cycle.
- Priority, highest first: rst, branchmiss, stomp, consume/fill.
- branchmiss: all valids ← 0, fetchbuf ← 0, did_branchback ← 0. No fill that cycle.
- Consume:
  - enq_cnt clears valid slots of the active pair in order, slot0 first then slot1.
  - Counts beyond the number of valid slots are ignored.
  - enq_cnt is ignored in a stomp cycle.
- Toggle: if the active pair is empty after consume (both invalid), fetchbuf ← ~fetchbuf.
- Fill:
  - Enabled when hit & ~irq & ~branchmiss.
  - Target: AB if A_v=B_v=0, else CD if C_v=D_v=0, else none.
  - Load instr0←insn0, pc0←pc, instr1←insn1, pc1←pc+INSN_BYTES; both valids ← 1, visible next cycle.
  - Fill and consume on different pairs in the same cycle are both performed.
  - Fill is suppressed in a stomp cycle.
- Stomp (branchback=1 and did_branchback=0), one cycle:
  - If slot0 is the backward branch: slot1 valid ← 0.
  - In both cases the inactive pair valids ← 0 (wrong path).
  - If slot1 is the backward branch and slot0 is not: did_branchback ← 1.
- did_branchback clears when slot1 of the active pair is consumed, on branchmiss, or on toggle.
- Latency: fill→visible 1 cycle. branchback is combinational from registered state.

Test Plan:
- Reset then idle: rst=1 for 2 clocks → all fetchbufX_v=0, fetchbuf=0, branchback=0, did_branchback=0.
- Basic fill/consume: pc=32'h1000, hit=1, insn0/1 non-branch → next cycle A_v=B_v=1, fb1_pc=32'h1005, CD filled the cycle after; enq_cnt=2 → AB cleared, fetchbuf=1.
- Slot0 backward branch: insn0 opcode 7'h28 with disp=-16, pc=32'h2000, CD valid → branchback=1, backpc=32'h1FF0; next cycle B_v=0 and C_v=D_v=0.
- Slot1 backward branch: insn1 branch at pc1=32'h3005, disp=-5 → backpc=32'h3000; next cycle did_branchback=1, CD invalid; enq_cnt=2 → did_branchback=0, fetchbuf toggles.
- Flush priority: branchmiss=1 with hit=1, enq_cnt=2, all pairs valid → next cycle all valids 0, fetchbuf=0, no fill.
- Fill blocked / over-consume: irq=1 with both pairs empty → no fill; enq_cnt=2 with only slot1 valid → slot1 cleared, fetchbuf toggles, no error.

Source files
------------

// File: rtl/thor2024_fetch_buffer.sv
// thor2024_fetch_buffer: two-pair (AB/CD) fetch buffer with backward-branch detection.
//   in : clk, rst, hit, irq, pc, insn0, insn1, branchmiss, enq_cnt
//   out: fetchbuf, fetchbufA_v..D_v, backbrA..D, branchback, backpc, did_branchback,
//        fb0/fb1 instr, pc and valid of the active pair
module thor2024_fetch_buffer #(
  parameter int INSN_W = 40,
  parameter int PC_W = 32,
  parameter int INSN_BYTES = 5,
  parameter logic [6:0] BR_MASK = 7'h78,
  parameter logic [6:0] BR_VAL = 7'h28,
  parameter int DISP_LSB = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic irq,
  input  logic [PC_W-1:0] pc,
  input  logic [INSN_W-1:0] insn0,
  input  logic [INSN_W-1:0] insn1,
  input  logic branchmiss,
  input  logic [1:0] enq_cnt,
  output logic fetchbuf,
  output logic fetchbufA_v,
  output logic fetchbufB_v,
  output logic fetchbufC_v,
  output logic fetchbufD_v,
  output logic backbrA,
  output logic backbrB,
  output logic backbrC,
  output logic backbrD,
  output logic branchback,
  output logic [PC_W-1:0] backpc,
  output logic did_branchback,
  output logic [INSN_W-1:0] fb0_instr,
  output logic [INSN_W-1:0] fb1_instr,
  output logic [PC_W-1:0] fb0_pc,
  output logic [PC_W-1:0] fb1_pc,
  output logic fb0_v,
  output logic fb1_v
);
  localparam int DW = INSN_W - DISP_LSB;
  logic [INSN_W-1:0] ins [4];
  logic [PC_W-1:0] pcs [4];
  logic [PC_W-1:0] tgt [4];
  logic [3:0] v, bb, sv, cv;
  logic fb, dbb, br0, br1, stomp, c0, c1, tog, fill_ab, fill_cd;
  logic [1:0] s0, s1;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bb[i] = ((ins[i][6:0] & BR_MASK) == BR_VAL) & ins[i][INSN_W-1];
      tgt[i] = pcs[i] + {{(PC_W-DW){ins[i][INSN_W-1]}}, ins[i][INSN_W-1:DISP_LSB]};
    end
  end
  assign s0 = {fb, 1'b0};
  assign s1 = {fb, 1'b1};
  assign br0 = v[s0] & bb[s0];
  assign br1 = v[s1] & bb[s1];
  assign stomp = (br0 | br1) & ~dbb;
  // enq_cnt takes the first valid slot(s) in order; surplus count is dropped
  assign c0 = v[s0] & (enq_cnt != 2'd0);
  assign c1 = v[s1] & (enq_cnt > (v[s0] ? 2'd1 : 2'd0));
  assign tog = ~(v[s0] & ~c0) & ~(v[s1] & ~c1);
  assign fill_ab = hit & ~irq & ~v[0] & ~v[1];
  assign fill_cd = hit & ~irq & ~fill_ab & ~v[2] & ~v[3];
  always_comb begin
    sv = v & (fb ? 4'b1100 : 4'b0011);
    sv[s1] = sv[s1] & ~br0;
    cv = v;
    cv[s0] = v[s0] & ~c0;
    cv[s1] = v[s1] & ~c1;
    cv = cv | {{2{fill_cd}}, {2{fill_ab}}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      fb <= 1'b0;
      dbb <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ins[i] <= '0;
        pcs[i] <= '0;
      end
    end else if (branchmiss) begin
      v <= '0;
      fb <= 1'b0;
      dbb <= 1'b0;
    end else if (stomp) begin
      v <= sv;
      dbb <= ~br0;
    end else begin
      v <= cv;
      fb <= fb ^ tog;
      dbb <= dbb & ~c1 & ~tog;
      if (fill_ab | fill_cd) begin
        ins[{fill_cd, 1'b0}] <= insn0;
        ins[{fill_cd, 1'b1}] <= insn1;
        pcs[{fill_cd, 1'b0}] <= pc;
        pcs[{fill_cd, 1'b1}] <= pc + PC_W'(INSN_BYTES);
      end
    end
  end
  assign fetchbuf = fb;
  assign {fetchbufD_v, fetchbufC_v, fetchbufB_v, fetchbufA_v} = v;
  assign {backbrD, backbrC, backbrB, backbrA} = bb;
  assign branchback = br0 | br1;
  assign backpc = br0 ? tgt[s0] : tgt[s1];
  assign did_branchback = dbb;
  assign fb0_instr = ins[s0];
  assign fb1_instr = ins[s1];
  assign fb0_pc = pcs[s0];
  assign fb1_pc = pcs[s1];
  assign fb0_v = v[s0];
  assign fb1_v = v[s1];
endmodule

// File: tb/tb_thor2024_fetch_buffer.sv
// tb_thor2024_fetch_buffer: scoreboard bench for thor2024_fetch_buffer.
module tb_thor2024_fetch_buffer;
  logic clk = 0, rst = 1, hit = 0, irq = 0, branchmiss = 0;
  logic [31:0] pc = '0;
  logic [39:0] insn0 = '0, insn1 = '0;
  logic [1:0] enq_cnt = '0;
  logic fetchbuf, fav, fbv, fcv, fdv, bba, bbb, bbc, bbd, branchback, did_branchback;
  logic [31:0] backpc, fb0_pc, fb1_pc;
  logic [39:0] fb0_instr, fb1_instr;
  logic fb0_v, fb1_v;
  int tests = 0, fails = 0;
  typedef struct {string nm; logic [74:0] ex; logic [74:0] m;} exp_t;
  exp_t q[$];
  localparam logic [39:0] NB = 40'h00_0000_0001;
  localparam logic [39:0] BR16 = {21'h1FFFF0, 12'h0, 7'h28};
  localparam logic [39:0] BR5 = {21'h1FFFFB, 12'h0, 7'h28};

  thor2024_fetch_buffer dut (
    .clk(clk), .rst(rst), .hit(hit), .irq(irq), .pc(pc), .insn0(insn0), .insn1(insn1),
    .branchmiss(branchmiss), .enq_cnt(enq_cnt), .fetchbuf(fetchbuf),
    .fetchbufA_v(fav), .fetchbufB_v(fbv), .fetchbufC_v(fcv), .fetchbufD_v(fdv),
    .backbrA(bba), .backbrB(bbb), .backbrC(bbc), .backbrD(bbd),
    .branchback(branchback), .backpc(backpc), .did_branchback(did_branchback),
    .fb0_instr(fb0_instr), .fb1_instr(fb1_instr), .fb0_pc(fb0_pc), .fb1_pc(fb1_pc),
    .fb0_v(fb0_v), .fb1_v(fb1_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      logic [74:0] obs;
      e = q.pop_front();
      obs = {fdv, fcv, fbv, fav, fetchbuf, did_branchback, branchback,
             bbd, bbc, bbb, bba, backpc, fb0_pc};
      tests++;
      if (((obs ^ e.ex) & e.m) != '0) begin
        fails++;
        $display("FAIL %s: got %h expected %h (mask %h)", e.nm, obs & e.m, e.ex & e.m, e.m);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] v, input logic f, input logic d,
                     input logic b, input logic cbr, input logic [3:0] br,
                     input logic cbp, input logic [31:0] bp, input logic cf, input logic [31:0] f0);
    exp_t e;
    e.nm = nm;
    e.ex = {v, f, d, b, br, bp, f0};
    e.m = {7'h7F, {4{cbr}}, {32{cbp}}, {32{cf}}};
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #2;
    chk("reset", 4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    rst = 0;
    hit = 1; pc = 32'h1000; insn0 = NB; insn1 = NB;
    chk("fill_ab", 4'b0011, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    pc = 32'h1010;
    chk("fill_cd", 4'b1111, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1000);
    hit = 0; enq_cnt = 2;
    chk("consume_ab", 4'b1100, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1010);
    enq_cnt = 0; hit = 1; pc = 32'h2000; insn0 = BR16; insn1 = NB;
    chk("fill_br0", 4'b1111, 1, 0, 0, 1, 4'b0001, 0, 0, 0, 0);
    hit = 0; enq_cnt = 2;
    chk("toggle_br0", 4'b0011, 0, 0, 1, 0, 0, 1, 32'h1FF0, 1, 32'h2000);
    hit = 1; pc = 32'h2100; insn0 = NB;
    chk("stomp_slot0", 4'b0001, 0, 0, 1, 0, 0, 1, 32'h1FF0, 0, 0);
    hit = 0; enq_cnt = 0; branchmiss = 1;
    chk("flush_stomp", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    branchmiss = 0; hit = 1; pc = 32'h3000; insn0 = NB; insn1 = BR5;
    chk("fill_br1", 4'b0011, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    hit = 0;
    chk("toggle_br1", 4'b0011, 0, 0, 1, 1, 4'b0010, 1, 32'h3000, 1, 32'h3000);
    hit = 1; pc = 32'h4000; insn1 = NB;
    chk("stomp_slot1", 4'b0011, 0, 1, 1, 0, 0, 1, 32'h3000, 0, 0);
    chk("fill_dbb", 4'b1111, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    hit = 0; enq_cnt = 2;
    chk("consume_dbb", 4'b1100, 1, 0, 0, 0, 0, 0, 0, 1, 32'h4000);
    enq_cnt = 0; hit = 1; pc = 32'h5000;
    chk("refill", 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    branchmiss = 1; enq_cnt = 2;
    chk("flush_prio", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    branchmiss = 0; enq_cnt = 0; irq = 1; pc = 32'h6000;
    chk("irq_block1", 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("irq_block2", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    irq = 0;
    chk("fill6", 4'b0011, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    hit = 0;
    chk("toggle6", 4'b0011, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6000);
    enq_cnt = 1;
    chk("consume_one", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6000);
    enq_cnt = 2;
    chk("over_consume", 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    enq_cnt = 0;
    @(posedge clk); #2;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
